// File: rtl/ddr2_phy_pkg.sv
// Shared DDR2 PHY definitions: IODELAY calibration states, default sweep
// constants and the window-centre helper.
package ddr2_phy_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_RST_TAP,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_STEP_UP,
    ST_CHECK,
    ST_STEP_DN,
    ST_DONE,
    ST_FAIL
  } cal_state_t;

  localparam int DEF_TAP_MAX    = 63;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_SAMPLES    = 16;
  localparam int DEF_MIN_WINDOW = 4;

  function automatic int unsigned tap_center(input int unsigned start_tap,
                                             input int unsigned end_tap);
    return (start_tap + end_tap) >> 1;
  endfunction

endpackage

// File: rtl/cal_window_track.sv
// Tracks the open run of passing taps and the widest closed run seen so far.
// A wider run replaces the best only when strictly wider, so ties keep the first.
module cal_window_track #(
  parameter int TW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_eval,
  input  logic          i_pass,
  input  logic          i_flush,
  input  logic [TW-1:0] i_tap,
  output logic [TW-1:0] o_best_start,
  output logic [TW-1:0] o_best_end,
  output logic [TW:0]   o_best_width
);

  logic          r_open;
  logic [TW-1:0] r_cur_start;
  logic [TW-1:0] r_best_start;
  logic [TW-1:0] r_best_end;
  logic [TW:0]   r_best_width;

  logic          w_close;
  logic [TW-1:0] w_run_start;
  logic [TW-1:0] w_run_end;
  logic [TW:0]   w_run_width;

  // A run closes either on a failing tap (ending one tap earlier) or is
  // flushed at the last tap while still passing.
  always_comb begin
    w_close     = 1'b0;
    w_run_start = r_cur_start;
    w_run_end   = i_tap;
    if (i_eval) begin
      if (i_pass && i_flush) begin
        w_close     = 1'b1;
        w_run_start = r_open ? r_cur_start : i_tap;
      end else if (!i_pass && r_open) begin
        w_close   = 1'b1;
        w_run_end = i_tap - TW'(1);
      end
    end
    w_run_width = {1'b0, w_run_end} - {1'b0, w_run_start} + (TW+1)'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_open       <= 1'b0;
      r_cur_start  <= '0;
      r_best_start <= '0;
      r_best_end   <= '0;
      r_best_width <= '0;
    end else if (i_clear) begin
      r_open       <= 1'b0;
      r_cur_start  <= '0;
      r_best_start <= '0;
      r_best_end   <= '0;
      r_best_width <= '0;
    end else if (i_eval) begin
      r_open <= i_pass && !i_flush;
      if (i_pass && !r_open) begin
        r_cur_start <= i_tap;
      end
      if (w_close && (w_run_width > r_best_width)) begin
        r_best_start <= w_run_start;
        r_best_end   <= w_run_end;
        r_best_width <= w_run_width;
      end
    end
  end

  assign o_best_start = r_best_start;
  assign o_best_end   = r_best_end;
  assign o_best_width = r_best_width;

endmodule

// File: rtl/ddr2_idelay_tap_cal.sv
// IODELAY tap calibration: waits for IDELAYCTRL ready, sweeps all taps against
// the training comparator, then steps back to the centre of the widest window.
module ddr2_idelay_tap_cal
  import ddr2_phy_pkg::*;
#(
  parameter int TAP_MAX    = DEF_TAP_MAX,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int SAMPLES    = DEF_SAMPLES,
  parameter int MIN_WINDOW = DEF_MIN_WINDOW,
  localparam int TW        = $clog2(TAP_MAX + 1)
) (
  input  logic          clk200,
  input  logic          rst,
  input  logic          idelay_ctrl_rdy,
  input  logic          cal_start,
  input  logic          sample_valid,
  input  logic          sample_ok,
  output logic          dly_rst,
  output logic          dly_ce,
  output logic          dly_inc,
  output logic [TW-1:0] tap_value,
  output logic [TW-1:0] win_start,
  output logic [TW-1:0] win_end,
  output logic          busy,
  output logic          cal_done,
  output logic          cal_fail
);

  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int SNW = $clog2(SAMPLES + 1);

  cal_state_t     r_state;
  cal_state_t     w_state_nxt;
  logic           r_rdy_meta;
  logic           r_rdy_s;
  logic [SCW-1:0] r_settle_cnt;
  logic [SNW-1:0] r_sample_cnt;
  logic           r_tap_fail;
  logic [TW-1:0]  r_tap;
  logic [TW-1:0]  r_centre;
  logic           r_dn_gap;
  logic           r_inc_last;

  logic           w_rst_tap;
  logic           w_ce;
  logic           w_dir_up;
  logic           w_eval;
  logic           w_flush;
  logic [TW-1:0]  w_best_start;
  logic [TW-1:0]  w_best_end;
  logic [TW:0]    w_best_width;

  // IDELAYCTRL RDY crosses in from another domain
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_rdy_meta <= 1'b0;
      r_rdy_s    <= 1'b0;
    end else begin
      r_rdy_meta <= idelay_ctrl_rdy;
      r_rdy_s    <= r_rdy_meta;
    end
  end

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Losing ready in any sweep state aborts before another tap move is issued.
  always_comb begin
    w_state_nxt = r_state;
    w_rst_tap   = 1'b0;
    w_ce        = 1'b0;
    w_dir_up    = 1'b0;
    w_eval      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (cal_start) w_state_nxt = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (r_rdy_s) w_state_nxt = ST_RST_TAP;
      end
      default: begin
        if (!r_rdy_s) begin
          w_state_nxt = ST_WAIT_RDY;
        end else begin
          case (r_state)
            ST_RST_TAP: begin
              w_rst_tap   = 1'b1;
              w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
              if (r_settle_cnt == SCW'(SETTLE_CYC - 1)) w_state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
              if (sample_valid && (r_sample_cnt == SNW'(SAMPLES - 1))) w_state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
              w_eval      = 1'b1;
              w_flush     = (r_tap == TW'(TAP_MAX));
              w_state_nxt = w_flush ? ST_CHECK : ST_STEP_UP;
            end
            ST_STEP_UP: begin
              w_ce        = 1'b1;
              w_dir_up    = 1'b1;
              w_state_nxt = ST_SETTLE;
            end
            ST_CHECK: begin
              w_state_nxt = (w_best_width >= (TW+1)'(MIN_WINDOW)) ? ST_STEP_DN : ST_FAIL;
            end
            ST_STEP_DN: begin
              if (!r_dn_gap) begin
                if (r_tap > r_centre) w_ce = 1'b1;
                else                  w_state_nxt = ST_DONE;
              end
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_settle_cnt <= '0;
      r_sample_cnt <= '0;
      r_tap_fail   <= 1'b0;
      r_tap        <= '0;
      r_centre     <= '0;
      r_dn_gap     <= 1'b0;
      r_inc_last   <= 1'b0;
    end else begin
      r_settle_cnt <= (r_state == ST_SETTLE) ? r_settle_cnt + SCW'(1) : '0;
      if (r_state != ST_SAMPLE) begin
        r_sample_cnt <= '0;
        r_tap_fail   <= 1'b0;
      end else if (sample_valid) begin
        r_sample_cnt <= r_sample_cnt + SNW'(1);
        if (!sample_ok) r_tap_fail <= 1'b1;
      end
      if (w_rst_tap) begin
        r_tap <= '0;
      end else if (w_ce) begin
        r_tap      <= w_dir_up ? r_tap + TW'(1) : r_tap - TW'(1);
        r_inc_last <= w_dir_up;
      end
      if (r_state == ST_CHECK) begin
        r_centre <= TW'(tap_center(32'(w_best_start), 32'(w_best_end)));
      end
      // Every step-down pulse is followed by one idle cycle
      r_dn_gap <= (r_state == ST_STEP_DN) && w_ce;
    end
  end

  cal_window_track #(
    .TW(TW)
  ) u_window (
    .i_clk        (clk200),
    .i_rst        (rst),
    .i_clear      (w_rst_tap),
    .i_eval       (w_eval),
    .i_pass       (!r_tap_fail),
    .i_flush      (w_flush),
    .i_tap        (r_tap),
    .o_best_start (w_best_start),
    .o_best_end   (w_best_end),
    .o_best_width (w_best_width)
  );

  assign dly_rst   = w_rst_tap;
  assign dly_ce    = w_ce;
  assign dly_inc   = w_ce ? w_dir_up : r_inc_last;
  assign tap_value = r_tap;
  assign win_start = w_best_start;
  assign win_end   = w_best_end;
  assign busy      = !((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL));
  assign cal_done  = (r_state == ST_DONE);
  assign cal_fail  = (r_state == ST_FAIL);

endmodule
